// File: rtl/sub_serial_11bit.sv
// Bit-serial unsigned subtractor: minuend - subtrahend, one bit per cycle, LSB first.
// Result and borrow update only when the final bit is done; done pulses for one cycle.
module sub_serial_11bit #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH:0]   minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [WIDTH:0] r_m;
    logic [WIDTH:0] r_s;
    logic [WIDTH:0] r_sh;
    logic           r_bin;
    logic [CW-1:0]  r_cnt;
    logic [WIDTH:0] r_diff;
    logic           r_borrow;
    logic           w_d;
    logic           w_bout;
    logic           w_last;
    logic           w_accept;

    assign w_d      = r_m[0] ^ r_s[0] ^ r_bin;
    assign w_bout   = (~r_m[0] & r_s[0]) | (~(r_m[0] ^ r_s[0]) & r_bin);
    assign w_last   = (r_cnt == CW'(WIDTH));
    assign w_accept = start && (r_state != RUN);

    assign diff   = r_diff;
    assign borrow = r_borrow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = start ? RUN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operands shift right so bit 0 is always the one being processed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m      <= '0;
            r_s      <= '0;
            r_sh     <= '0;
            r_bin    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_m   <= minuend;
            r_s   <= {1'b0, subtrahend};
            r_sh  <= '0;
            r_bin <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_m   <= r_m >> 1;
            r_s   <= r_s >> 1;
            r_bin <= w_bout;
            r_sh  <= {w_d, r_sh[WIDTH:1]};
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_diff   <= {w_d, r_sh[WIDTH:1]};
                r_borrow <= w_bout;
            end
        end
    end

endmodule

// File: tb/tb_sub_serial_11bit.sv
// Bench for sub_serial_11bit: cycle-level reference model plus directed corner cases and random traffic.
module tb_sub_serial_11bit;

    localparam int W = 11;
    typedef logic [W:0]   m_t;
    typedef logic [W-1:0] s_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    m_t   minuend = '0;
    s_t   subtrahend = '0;
    logic busy;
    logic done;
    m_t   diff;
    logic borrow;

    int vectors = 0;
    int errors  = 0;

    sub_serial_11bit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow     (borrow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: an operation is a countdown of W+1 edges ending in a
    // one-cycle done, with the result computed as plain modular subtraction.
    logic m_run = 1'b0;
    logic m_done = 1'b0;
    m_t   m_diff = '0;
    logic m_borrow = 1'b0;
    m_t   m_pd = '0;
    logic m_pb = 1'b0;
    int   m_rem = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run    <= 1'b0;
            m_done   <= 1'b0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
            m_rem    <= 0;
        end else if (m_run) begin
            if (m_rem == 1) begin
                m_run    <= 1'b0;
                m_done   <= 1'b1;
                m_diff   <= m_pd;
                m_borrow <= m_pb;
            end
            m_rem <= m_rem - 1;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_run <= 1'b1;
                m_rem <= W + 1;
                m_pd  <= minuend - {1'b0, subtrahend};
                m_pb  <= ({1'b0, subtrahend} > minuend);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",   {31'd0, busy},   {31'd0, m_run});
        chk("done",   {31'd0, done},   {31'd0, m_done});
        chk("diff",   {20'd0, diff},   {20'd0, m_diff});
        chk("borrow", {31'd0, borrow}, {31'd0, m_borrow});
        chk("busy_and_done", {31'd0, busy & done}, 32'd0);
    end

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input string nm, input m_t m, input s_t s, input m_t ed, input logic eb);
        int k;
        @(negedge clk);
        minuend    = m;
        subtrahend = s;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        chk({nm, "_latency"}, k, 32'd12);
        chk({nm, "_diff"}, {20'd0, diff}, {20'd0, ed});
        chk({nm, "_borrow"}, {31'd0, borrow}, {31'd0, eb});
        @(negedge clk);
    endtask

    initial begin
        int k;
        int pulses;

        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_diff", {20'd0, diff}, 32'd0);
        rst = 1'b0;

        run_op("max_sum",   m_t'(4094), s_t'(2047), m_t'(2047), 1'b0);
        run_op("underflow", m_t'(0),    s_t'(1),    m_t'(12'hFFF), 1'b1);
        run_op("rt_a",      m_t'(1801), s_t'(567),  m_t'(1234), 1'b0);
        run_op("rt_b",      m_t'(1801), s_t'(1234), m_t'(567),  1'b0);

        // start re-pulsed mid-run with different operands
        @(negedge clk);
        minuend = m_t'(3000); subtrahend = s_t'(1000); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        minuend = m_t'(5); subtrahend = s_t'(2000); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 5;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ignore_latency", k, 32'd12);
        chk("ignore_diff", {20'd0, diff}, 32'd2000);
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("ignore_extra_done", pulses, 32'd0);

        // back-to-back: start held through the DONE cycle
        @(negedge clk);
        minuend = m_t'(100); subtrahend = s_t'(30); start = 1'b1;
        @(negedge clk);
        wait_done(k);
        chk("b2b_first_latency", k, 32'd12);
        chk("b2b_first_diff", {20'd0, diff}, 32'd70);
        minuend = m_t'(10); subtrahend = s_t'(20);
        @(negedge clk);
        k++;
        start = 1'b0;
        chk("b2b_rerun_busy", {31'd0, busy}, 32'd1);
        chk("b2b_rerun_done", {31'd0, done}, 32'd0);
        while (done !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_second_latency", k, 32'd25);
        chk("b2b_second_diff", {20'd0, diff}, 32'd4086);
        chk("b2b_second_borrow", {31'd0, borrow}, 32'd1);
        @(negedge clk);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        minuend = m_t'(777); subtrahend = s_t'(111); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy",   {31'd0, busy},   32'd0);
        chk("arst_done",   {31'd0, done},   32'd0);
        chk("arst_diff",   {20'd0, diff},   32'd0);
        chk("arst_borrow", {31'd0, borrow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("arst_no_done", pulses, 32'd0);
        run_op("after_rst", m_t'(777), s_t'(111), m_t'(666), 1'b0);

        // random traffic checked cycle by cycle against the model
        repeat (600) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0: minuend = '0;
                1: minuend = '1;
                default: minuend = m_t'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: subtrahend = '0;
                1: subtrahend = '1;
                default: subtrahend = s_t'($urandom);
            endcase
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sub_serial_11bit.md
SUB_SERIAL_11BIT -- requirements
Module: sub_serial_11bit

Interface
REQ-001 SHALL have parameter WIDTH, default 11, subtrahend width; minuend and diff are WIDTH+1 bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request; sampled on the rising edge.
REQ-005 SHALL have port minuend  input  WIDTH+1  operand; the adder-sum-width value.
REQ-006 SHALL have port subtrahend  input  WIDTH  operand; unsigned.
REQ-007 SHALL have port busy  output  1  high while bits are being processed.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port diff  output  WIDTH+1  result, minuend - subtrahend modulo 2^(WIDTH+1).
REQ-010 SHALL have port borrow  output  1  high when subtrahend > minuend.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE.
REQ-012 SHALL accept start only in IDLE or DONE, capturing minuend, zero-extended subtrahend and borrow-in=0 into internal registers at that edge (edge N), then enter RUN.
REQ-013 SHALL ignore start while in RUN; the captured operands are unaffected.
REQ-014 SHALL process one bit per RUN cycle, LSB first, with a 1-bit full subtractor: d = m^s^bin, bout = (~m&s)|(~(m^s)&bin).
REQ-015 SHALL shift each result bit into a diff shift register from the MSB side, so diff is fully aligned after WIDTH+1 bits.
REQ-016 SHALL use a bit counter 0..WIDTH and leave RUN at the edge that processes bit WIDTH (edge N+WIDTH+1 = N+12 for the default).
REQ-017 SHALL drive diff and borrow (the final bout) to their final values at edge N+12, in the same cycle done goes high.
REQ-018 SHALL hold done=1 for exactly the one DONE cycle, then return to IDLE unless start is sampled in DONE.
REQ-019 SHALL, on start sampled in DONE, re-enter RUN directly (back-to-back operation), with done low in the following cycle.
REQ-020 SHALL hold busy=1 exactly while in RUN (cycles N+1..N+12 for the default); busy and done are never both high.
REQ-021 SHALL hold diff and borrow stable from done until the edge where the next RUN completes.
REQ-022 SHALL NOT update diff or borrow with partial values during RUN; they remain visible and change only at completion.
REQ-023 SHALL treat both operands as unsigned with no saturation: minuend 0, subtrahend 1 gives diff all ones, borrow=1.

Reset
REQ-024 SHALL, on rst high, immediately force state to IDLE, busy=0, done=0, diff=0, borrow=0, and clear the counter and internal registers, independent of clk.
REQ-025 SHALL, when rst is asserted mid-RUN, abandon the operation with no done pulse; the first start after rst falls begins a fresh operation.
REQ-026 SHALL ignore start on any edge at which rst is high.

Verification
REQ-027 SHALL cover max adder sum: minuend=4094, subtrahend=2047 -> done exactly 12 cycles after the start edge, diff=2047, borrow=0.
REQ-028 SHALL cover underflow: minuend=0, subtrahend=1 -> diff=12'hFFF, borrow=1.
REQ-029 SHALL cover the round trip with the 11-bit adder: a=1234, b=567, sum=1801; subtract 567 -> diff=1234, borrow=0; subtract 1234 -> diff=567.
REQ-030 SHALL cover start during RUN: start re-pulsed at cycle N+5 with other operands -> ignored, result reflects the original operands, single done pulse.
REQ-031 SHALL cover back-to-back: start held high through DONE -> second operation completes 12 cycles later, done high in two non-adjacent cycles, busy low only in the DONE cycles.
REQ-032 SHALL cover reset mid-operation: rst pulsed at cycle N+6 -> busy, done, diff, borrow all 0 asynchronously; no done; next start yields a correct result.
